// File: rtl/int2fp_conv.sv
// Multi-cycle 32-bit signed/unsigned integer to IEEE-754 single converter.
// Iterative shift normalizer followed by a round-to-nearest-even step.
module int2fp_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mag;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic [31:0] r_out;

  logic        w_inSign;
  logic [31:0] w_absMag;
  logic        w_inc;
  logic [23:0] w_fracSum;
  logic [7:0]  w_expRnd;

  // Round step: carry out of the 23-bit fraction bumps the exponent.
  always_comb begin
    w_inSign  = in_data[31] & ~in_unsigned;
    w_absMag  = w_inSign ? (~in_data + 32'd1) : in_data;
    w_inc     = r_mag[7] & ((|r_mag[6:0]) | r_mag[8]);
    w_fracSum = {1'b0, r_mag[30:8]} + {23'd0, w_inc};
    w_expRnd  = r_exp + {7'd0, w_fracSum[23]};
  end

  // A zero operand skips NORM and passes through ROUND, so its result
  // appears one cycle after the accept edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (in_valid) w_next = (w_absMag == 32'd0) ? ROUND : NORM;
      NORM:  if (r_mag[31]) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mag   <= 32'd0;
      r_exp   <= 8'd0;
      r_sign  <= 1'b0;
      r_out   <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= w_inSign;
            r_mag  <= w_absMag;
            r_exp  <= 8'd158;
            if (w_absMag == 32'd0) r_out <= 32'd0;
          end
        end
        NORM: begin
          if (!r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        // A clear top bit here means the zero path: keep the zero already written.
        ROUND: begin
          if (r_mag[31]) r_out <= {r_sign, w_expRnd, w_fracSum[22:0]};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out;

endmodule
